// File: rtl/uart_tx_pkg.sv
// Shared types and encodings for the UART transmit controller.
// mux_sel drives a downstream 4:1 line mux: start(0), stop/idle(1), payload bit, parity bit.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  function automatic logic [1:0] sel_for(input state_t s);
    logic [1:0] sel;
    sel = SEL_STOP;
    case (s)
      START:   sel = SEL_START;
      DATA:    sel = SEL_DATA;
      PARITY:  sel = SEL_PAR;
      default: sel = SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Parity of the accepted payload, captured once per frame on acceptance.
// par_typ: 0 = even, 1 = odd.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (^data) ^ par_typ;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, DATA_WIDTH payload bits LSB first, optional parity, stop.
// Every output is registered; the STOP cycle can accept the next frame back-to-back.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   payload, payload_nxt;
  logic                    par_en_q, par_en_nxt;
  logic                    accept;
  logic [1:0]              mux_sel_nxt;
  logic                    ser_data_nxt;
  logic                    busy_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    payload_nxt = payload;
    par_en_nxt  = par_en_q;
    accept      = 1'b0;

    case (state)
      IDLE, STOP: begin
        if (Data_Valid) begin
          accept      = 1'b1;
          state_nxt   = START;
          payload_nxt = P_DATA;
          par_en_nxt  = PAR_EN;
        end else begin
          state_nxt   = IDLE;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      PARITY:  state_nxt = STOP;
      default: state_nxt = IDLE;
    endcase

    // Outputs are precomputed from the next state so the registers line up with it.
    mux_sel_nxt  = sel_for(state_nxt);
    busy_nxt     = (state_nxt != IDLE);
    ser_data_nxt = (state_nxt == DATA) ? payload_nxt[cnt_nxt] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      payload  <= '0;
      par_en_q <= 1'b0;
      mux_sel  <= SEL_STOP;
      ser_data <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      payload  <= payload_nxt;
      par_en_q <= par_en_nxt;
      mux_sel  <= mux_sel_nxt;
      ser_data <= ser_data_nxt;
      busy     <= busy_nxt;
    end
  end

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clk     (CLK),
    .rst     (RST),
    .load    (accept),
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit)
  );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle frame-queue model plus directed literal line traces.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a frame is a list of expected cycles; a new frame may start only
  // when nothing is queued, i.e. the line is idle or in its stop cycle.
  typedef struct {
    logic [1:0] mux;
    logic       ser;
    logic       busy;
    logic       par;
    bit         chk_ser;
    bit         chk_par;
  } exp_t;

  exp_t fq[$];
  exp_t cur;
  bit   model_on = 0;

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    logic p;
    p = (($countones(d) % 2) == 1) ^ pt;
    fq.push_back('{2'b00, 1'b0, 1'b1, p, 1'b0, 1'b1});
    for (int i = 0; i < 8; i++)
      fq.push_back('{2'b10, d[i], 1'b1, p, 1'b1, 1'b1});
    if (pe)
      fq.push_back('{2'b11, 1'b0, 1'b1, p, 1'b0, 1'b1});
    fq.push_back('{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      fq.delete();
      cur = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      model_on = 1;
    end else if (model_on) begin
      if (Data_Valid && fq.size() == 0)
        push_frame(P_DATA, PAR_EN, PAR_TYP);
      if (fq.size() > 0) cur = fq.pop_front();
      else               cur = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
  end

  always @(negedge CLK) begin
    if (model_on) begin
      n_checks++;
      if (mux_sel !== cur.mux || busy !== cur.busy ||
          (cur.chk_ser && ser_data !== cur.ser) ||
          (cur.chk_par && par_bit !== cur.par)) begin
        $display("FAIL model t=%0t got mux=%b busy=%b ser=%b par=%b expected mux=%b busy=%b ser=%b(%0d) par=%b(%0d)",
                 $time, mux_sel, busy, ser_data, par_bit,
                 cur.mux, cur.busy, cur.ser, cur.chk_ser, cur.par, cur.chk_par);
      end else begin
        n_pass++;
      end
    end
  end

  // Directed capture of the line as the downstream mux would drive it.
  logic [1:0] cap_mux  [0:63];
  logic       cap_line [0:63];
  logic       cap_busy [0:63];
  logic       cap_par  [0:63];

  function automatic logic line_of(input logic [1:0] m, input logic s, input logic p);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return s;
      default: return p;
    endcase
  endfunction

  task automatic cap(input int i);
    cap_mux[i]  = mux_sel;
    cap_line[i] = line_of(mux_sel, ser_data, par_bit);
    cap_busy[i] = busy;
    cap_par[i]  = par_bit;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s got %0d expected %0d", name, act, expv);
  endtask

  task automatic chk_line(input string name, input string s);
    logic [63:0] got, expv;
    got  = '0;
    expv = '0;
    for (int i = 0; i < s.len(); i++) begin
      got[i]  = cap_line[i];
      expv[i] = (s[i] == "1");
    end
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s got %b expected %b (bit0 = first cycle)", name, got, expv);
  endtask

  function automatic int busy_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(cap_busy[i]);
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_mux", int'(mux_sel), 1);
    chk("reset_busy", int'(busy), 0);
    RST = 1'b0;
    idle(2);

    // 0xA5, no parity
    start_frame(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK); Data_Valid = 1'b0; cap(i);
    end
    chk_line("a5_line", "01010010111");
    chk("a5_busy_cycles", busy_count(11), 10);
    idle(2);

    // 0xA5, even parity
    start_frame(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); Data_Valid = 1'b0; cap(i);
    end
    chk("a5_even_mux_par", int'(cap_mux[9]), 3);
    chk("a5_even_par_bit", int'(cap_par[9]), 0);
    chk("a5_even_busy_cycles", busy_count(12), 11);
    chk_line("a5_even_line", "010100101011");
    idle(2);

    // 0xA5, odd parity
    start_frame(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); Data_Valid = 1'b0; cap(i);
    end
    chk("a5_odd_par_bit", int'(cap_par[9]), 1);
    chk_line("a5_odd_line", "010100101111");
    idle(2);

    // 0x3C then 0xFF requested during the first frame's stop cycle
    start_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      if (i == 0 || i == 10) Data_Valid = 1'b0;
      cap(i);
      if (i == 9) start_frame(8'hFF, 1'b0, 1'b0);
    end
    chk_line("b2b_line", "000111100101111111111");
    chk("b2b_busy_cycles", busy_count(21), 20);
    chk("b2b_busy_low_after", int'(cap_busy[20]), 0);
    idle(2);

    // Data_Valid with 0x00 mid-frame must be ignored
    start_frame(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      cap(i);
      if (i == 3) start_frame(8'h00, 1'b0, 1'b0);
    end
    chk_line("ignore_dv_line", "010100101111");
    chk("ignore_dv_busy_cycles", busy_count(12), 10);
    idle(2);

    // Reset at data bit 4, then a clean 0x81 frame
    start_frame(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); Data_Valid = 1'b0; cap(i);
    end
    chk("pre_reset_par_bit", int'(cap_par[1]), 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_mux", int'(mux_sel), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_par_bit", int'(par_bit), 0);
    RST = 1'b0;
    start_frame(8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK); Data_Valid = 1'b0; cap(i);
    end
    chk_line("post_reset_81_line", "01000000111");
    chk("post_reset_81_busy", busy_count(11), 10);
    idle(2);

    // Data_Valid held for three frames of 0x55
    start_frame(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK); cap(i);
      if (i == 29) Data_Valid = 1'b0;
    end
    chk_line("held_55_line", "01010101010101010101010101010111");
    chk("held_55_busy_cycles", busy_count(32), 30);
    idle(2);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      RST        = ($urandom_range(0, 199) == 0);
      @(negedge CLK);
    end
    RST = 1'b0;
    Data_Valid = 1'b0;
    idle(15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, serial payload width in bits.
REQ-002 SHALL have port CLK  input  1  single clock; one serial bit per CLK cycle; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload, sampled only on frame acceptance.
REQ-005 SHALL have port Data_Valid  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  parity bit inserted when 1, sampled on acceptance.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd, sampled on acceptance.
REQ-008 SHALL have port mux_sel  output  2  line-source select for the downstream 4:1 output mux: 00 start (0), 01 stop/idle (1), 10 ser_data, 11 par_bit.
REQ-009 SHALL have port ser_data  output  1  current payload bit, LSB first.
REQ-010 SHALL have port par_bit  output  1  parity of latched payload.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 SHALL, in IDLE with Data_Valid=1 at an edge, latch P_DATA/PAR_EN/PAR_TYP and enter START next cycle.
REQ-014 SHALL hold START exactly 1 cycle (mux_sel=00), then DATA.
REQ-015 SHALL hold DATA exactly DATA_WIDTH cycles, mux_sel=10, ser_data = latched bit[cnt], cnt 0..DATA_WIDTH-1.
REQ-016 SHALL, after the last data bit, enter PARITY if latched PAR_EN=1 (1 cycle, mux_sel=11), else STOP.
REQ-017 SHALL hold STOP exactly 1 cycle (mux_sel=01), then IDLE.
REQ-018 SHALL compute par_bit = XOR of latched payload for even, its inverse for odd; valid from START through end of PARITY.
REQ-019 SHALL drive busy=1 in START, DATA, PARITY, STOP; busy=0 in IDLE.
REQ-020 SHALL give frame length 2+DATA_WIDTH cycles without parity, 3+DATA_WIDTH with parity.
REQ-021 SHALL ignore Data_Valid in START, DATA and PARITY; input changes there do not affect the frame in flight.
REQ-022 SHALL accept Data_Valid=1 during the STOP cycle as a back-to-back frame: latch inputs, go directly to START, busy stays 1.
REQ-023 SHALL drive mux_sel=01 in IDLE so the line idles high.
REQ-024 SHALL wrap the bit counter to 0 on leaving DATA; counter width ceil(log2(DATA_WIDTH)).

Reset
REQ-025 SHALL, while RST=1 at an edge, force state IDLE, mux_sel=01, busy=0, ser_data=0, par_bit=0, counter=0, latched payload=0.
REQ-026 SHALL abort any frame on RST mid-frame; the first post-reset cycle is IDLE with no residual bits.
REQ-027 SHALL ignore Data_Valid in a cycle where RST=1.

Structure
REQ-028 SHALL place the state enum, mux_sel encodings (SEL_START, SEL_STOP, SEL_DATA, SEL_PAR) and default DATA_WIDTH in shared package uart_tx_pkg.
REQ-029 SHALL implement parity as sub-module parity_calc (payload + PAR_TYP in, par_bit out, registered on acceptance).

Verification
REQ-030 SHALL cover: P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> line (via mux) 0,1,0,1,0,0,1,0,1,1 then idle 1; busy high exactly 10 cycles.
REQ-031 SHALL cover: 0xA5, PAR_EN=1, PAR_TYP=0 -> par_bit=0, mux_sel=11 in cycle 10, 11-cycle frame; PAR_TYP=1 -> par_bit=1.
REQ-032 SHALL cover: 0x3C then 0xFF with Data_Valid high in the STOP cycle of the first -> START of second immediately after STOP, busy never drops, 20 busy cycles total.
REQ-033 SHALL cover: Data_Valid pulsed with P_DATA=0x00 during DATA of a 0xA5 frame -> 0xA5 frame unchanged, no second frame.
REQ-034 SHALL cover: RST asserted at data bit 4 of a frame -> next cycle IDLE, mux_sel=01, busy=0, par_bit=0; new 0x81 frame then transmits correctly.
REQ-035 SHALL cover: Data_Valid held high continuously for 3 frames of 0x55 -> three contiguous 10-cycle frames, no idle gap.
